// File: rtl/stage_execute.sv
// -----------------------------------------------------------------------------
// stage_execute
//   Execute stage between decode and memory. It resolves operand forwarding,
//   computes a 4-lane x 32-bit ALU result and registers everything into the
//   EX/MEM pipeline register. A multiply runs for MUL_CYCLES busy cycles under
//   a small FSM that stalls the front end.
//
// Handshake / flow control (one rule for the whole block):
//   ex_stall_all=1 means "hold the ex_* inputs stable, this stage is not
//   accepting a new instruction". The EX/MEM register loads only when
//   mem_clear=0 and mem_stall=0; mem_clear wins over mem_stall.
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   ex_*                  : decoded instruction, control and operands
//   forward_a/forward_b   : 00/11 register file, 01 wb_fwd_result, 10 mem_fwd_result
//   mem_fwd_result,
//   wb_fwd_result         : forwarded values
//   mem_clear, mem_stall  : EX/MEM register flush and hold
//   ex_stall_all          : stall request to fetch/decode/execute (combinational)
//   mem_*                 : registered EX/MEM outputs
//   mul_state             : current multiply FSM state (debug)
// -----------------------------------------------------------------------------
module stage_execute #(
    parameter int MUL_CYCLES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  ex_instr,
    input  logic         ex_reg_write,
    input  logic         ex_mem_write,
    input  logic         ex_mem_read,
    input  logic         ex_vector_op,
    input  logic [1:0]   ex_result_src,
    input  logic [3:0]   ex_alu_control,
    input  logic         ex_alu_src,
    input  logic [127:0] ex_rd1,
    input  logic [127:0] ex_rd2,
    input  logic [127:0] ex_imm_ext,
    input  logic [31:0]  ex_pc_plus_4,
    input  logic [4:0]   ex_rd,
    input  logic [1:0]   forward_a,
    input  logic [1:0]   forward_b,
    input  logic [127:0] mem_fwd_result,
    input  logic [127:0] wb_fwd_result,
    input  logic         mem_clear,
    input  logic         mem_stall,
    output logic         ex_stall_all,
    output logic [31:0]  mem_instr,
    output logic         mem_reg_write,
    output logic         mem_mem_write,
    output logic         mem_mem_read,
    output logic         mem_vector_op,
    output logic [1:0]   mem_result_src,
    output logic [127:0] mem_alu_result,
    output logic [127:0] mem_write_data,
    output logic [127:0] mem_imm_ext,
    output logic [31:0]  mem_pc_plus_4,
    output logic [4:0]   mem_rd,
    output logic [1:0]   mul_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;

    localparam logic [3:0] LAST_COUNT = 4'(MUL_CYCLES - 1);

    logic [1:0]   state;
    logic [3:0]   count;
    logic [127:0] op_a;
    logic [127:0] op_b;
    logic [127:0] product;

    logic [127:0] src_a;
    logic [127:0] fwd_b;
    logic [127:0] src_b;
    logic [127:0] alu_lanes;
    logic [127:0] mul_lanes;
    logic [127:0] alu_result;
    logic         is_mul;
    logic         load;

    // Forwarding muxes
    always_comb begin
        case (forward_a)
            2'b01:   src_a = wb_fwd_result;
            2'b10:   src_a = mem_fwd_result;
            default: src_a = ex_rd1;
        endcase
        case (forward_b)
            2'b01:   fwd_b = wb_fwd_result;
            2'b10:   fwd_b = mem_fwd_result;
            default: fwd_b = ex_rd2;
        endcase
        src_b = ex_alu_src ? ex_imm_ext : fwd_b;
    end

    // Single-cycle lane ALU. Multiply yields 0 here; its result comes from
    // the product register once the FSM reaches DONE.
    always_comb begin
        logic [31:0] la;
        logic [31:0] lb;
        alu_lanes = '0;
        for (int i = 0; i < 4; i++) begin
            la = src_a[32*i +: 32];
            lb = src_b[32*i +: 32];
            case (ex_alu_control)
                ALU_ADD: alu_lanes[32*i +: 32] = la + lb;
                ALU_SUB: alu_lanes[32*i +: 32] = la - lb;
                ALU_AND: alu_lanes[32*i +: 32] = la & lb;
                ALU_OR:  alu_lanes[32*i +: 32] = la | lb;
                ALU_XOR: alu_lanes[32*i +: 32] = la ^ lb;
                ALU_SLL: alu_lanes[32*i +: 32] = la << lb[4:0];
                ALU_SRL: alu_lanes[32*i +: 32] = la >> lb[4:0];
                ALU_SLT: alu_lanes[32*i +: 32] = {31'd0, $signed(la) < $signed(lb)};
                default: alu_lanes[32*i +: 32] = 32'd0;
            endcase
        end
    end

    // Lane products from the captured operands, not the live sources, since
    // forwarded values move while the pipeline drains.
    always_comb begin
        mul_lanes = '0;
        for (int i = 0; i < 4; i++) begin
            mul_lanes[32*i +: 32] = op_a[32*i +: 32] * op_b[32*i +: 32];
        end
    end

    always_comb begin
        alu_result = (state == S_DONE) ? product : alu_lanes;
        if (!ex_vector_op) begin
            alu_result[127:32] = 96'd0;
        end
    end

    assign is_mul       = (ex_alu_control == ALU_MUL);
    assign load         = ~mem_clear & ~mem_stall;
    // Gated by reset so the request drops as soon as reset is asserted,
    // even when a multiply is still presented on the inputs.
    assign ex_stall_all = ~reset & (((state == S_IDLE) & is_mul) | (state == S_BUSY));
    assign mul_state    = state;

    // Multiply FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            count   <= 4'd0;
            op_a    <= '0;
            op_b    <= '0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_mul) begin
                        op_a  <= src_a;
                        op_b  <= src_b;
                        count <= 4'd0;
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    count <= count + 4'd1;
                    if (count == LAST_COUNT) begin
                        product <= mul_lanes;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Leave only when the EX/MEM register takes the product.
                    if (load) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // EX/MEM pipeline register. While the stage stalls it loads a bubble:
    // control, destination and instruction word forced to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_instr      <= '0;
            mem_reg_write  <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_vector_op  <= 1'b0;
            mem_result_src <= '0;
            mem_alu_result <= '0;
            mem_write_data <= '0;
            mem_imm_ext    <= '0;
            mem_pc_plus_4  <= '0;
            mem_rd         <= '0;
        end else if (mem_clear) begin
            mem_instr      <= '0;
            mem_reg_write  <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_vector_op  <= 1'b0;
            mem_result_src <= '0;
            mem_alu_result <= '0;
            mem_write_data <= '0;
            mem_imm_ext    <= '0;
            mem_pc_plus_4  <= '0;
            mem_rd         <= '0;
        end else if (!mem_stall) begin
            mem_instr      <= ex_stall_all ? 32'd0 : ex_instr;
            mem_reg_write  <= ex_reg_write & ~ex_stall_all;
            mem_mem_write  <= ex_mem_write & ~ex_stall_all;
            mem_mem_read   <= ex_mem_read & ~ex_stall_all;
            mem_vector_op  <= ex_vector_op & ~ex_stall_all;
            mem_result_src <= ex_stall_all ? 2'd0 : ex_result_src;
            mem_alu_result <= alu_result;
            mem_write_data <= fwd_b;
            mem_imm_ext    <= ex_imm_ext;
            mem_pc_plus_4  <= ex_pc_plus_4;
            mem_rd         <= ex_stall_all ? 5'd0 : ex_rd;
        end
    end

endmodule

// File: tb/tb_stage_execute.sv
// -----------------------------------------------------------------------------
// tb_stage_execute
//   Self-checking bench for stage_execute (MUL_CYCLES = 4). Expected ALU
//   results come from a lane-by-lane arithmetic model; pipeline timing
//   expectations come from the documented cycle counts.
// -----------------------------------------------------------------------------
module tb_stage_execute;

    localparam int MUL_CYCLES = 4;

    logic         clk;
    logic         reset;
    logic [31:0]  ex_instr;
    logic         ex_reg_write;
    logic         ex_mem_write;
    logic         ex_mem_read;
    logic         ex_vector_op;
    logic [1:0]   ex_result_src;
    logic [3:0]   ex_alu_control;
    logic         ex_alu_src;
    logic [127:0] ex_rd1;
    logic [127:0] ex_rd2;
    logic [127:0] ex_imm_ext;
    logic [31:0]  ex_pc_plus_4;
    logic [4:0]   ex_rd;
    logic [1:0]   forward_a;
    logic [1:0]   forward_b;
    logic [127:0] mem_fwd_result;
    logic [127:0] wb_fwd_result;
    logic         mem_clear;
    logic         mem_stall;
    logic         ex_stall_all;
    logic [31:0]  mem_instr;
    logic         mem_reg_write;
    logic         mem_mem_write;
    logic         mem_mem_read;
    logic         mem_vector_op;
    logic [1:0]   mem_result_src;
    logic [127:0] mem_alu_result;
    logic [127:0] mem_write_data;
    logic [127:0] mem_imm_ext;
    logic [31:0]  mem_pc_plus_4;
    logic [4:0]   mem_rd;
    logic [1:0]   mul_state;

    int total = 0;
    int bad   = 0;

    stage_execute #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk(clk), .reset(reset),
        .ex_instr(ex_instr), .ex_reg_write(ex_reg_write),
        .ex_mem_write(ex_mem_write), .ex_mem_read(ex_mem_read),
        .ex_vector_op(ex_vector_op), .ex_result_src(ex_result_src),
        .ex_alu_control(ex_alu_control), .ex_alu_src(ex_alu_src),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm_ext(ex_imm_ext),
        .ex_pc_plus_4(ex_pc_plus_4), .ex_rd(ex_rd),
        .forward_a(forward_a), .forward_b(forward_b),
        .mem_fwd_result(mem_fwd_result), .wb_fwd_result(wb_fwd_result),
        .mem_clear(mem_clear), .mem_stall(mem_stall),
        .ex_stall_all(ex_stall_all),
        .mem_instr(mem_instr), .mem_reg_write(mem_reg_write),
        .mem_mem_write(mem_mem_write), .mem_mem_read(mem_mem_read),
        .mem_vector_op(mem_vector_op), .mem_result_src(mem_result_src),
        .mem_alu_result(mem_alu_result), .mem_write_data(mem_write_data),
        .mem_imm_ext(mem_imm_ext), .mem_pc_plus_4(mem_pc_plus_4),
        .mem_rd(mem_rd), .mul_state(mul_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] pick(input logic [1:0] sel, input logic [127:0] rf,
                                          input logic [127:0] wb, input logic [127:0] mem);
        if (sel == 2'b01) return wb;
        if (sel == 2'b10) return mem;
        return rf;
    endfunction

    function automatic logic [127:0] alu_model(input logic [3:0] op, input logic vec,
                                               input logic [127:0] a, input logic [127:0] b);
        logic [127:0] r;
        longint unsigned ua, ub;
        longint sa, sb;
        r = '0;
        for (int i = 0; i < (vec ? 4 : 1); i++) begin
            ua = longint'(a[32*i +: 32]);
            ub = longint'(b[32*i +: 32]);
            sa = longint'($signed(a[32*i +: 32]));
            sb = longint'($signed(b[32*i +: 32]));
            case (op)
                4'd0: r[32*i +: 32] = 32'(ua + ub);
                4'd1: r[32*i +: 32] = 32'(ua + 64'h1_0000_0000 - ub);
                4'd2: r[32*i +: 32] = 32'(ua & ub);
                4'd3: r[32*i +: 32] = 32'(ua | ub);
                4'd4: r[32*i +: 32] = 32'(ua ^ ub);
                4'd5: r[32*i +: 32] = 32'(ua * (64'd1 << (ub % 32)));
                4'd6: r[32*i +: 32] = 32'(ua / (64'd1 << (ub % 32)));
                4'd7: r[32*i +: 32] = (sa < sb) ? 32'd1 : 32'd0;
                4'd8: r[32*i +: 32] = 32'(ua * ub);
                default: r[32*i +: 32] = 32'd0;
            endcase
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_op(input logic [3:0] op, input logic vec,
                          input logic [127:0] a, input logic [127:0] b);
        ex_alu_control = op;
        ex_vector_op   = vec;
        ex_rd1         = a;
        ex_rd2         = b;
        ex_alu_src     = 1'b0;
        forward_a      = 2'b00;
        forward_b      = 2'b00;
        ex_reg_write   = 1'b1;
        ex_mem_write   = 1'b0;
        ex_mem_read    = 1'b0;
        ex_result_src  = 2'b01;
        ex_rd          = 5'($urandom_range(1, 31));
        ex_instr       = $urandom | 32'h1;
        ex_pc_plus_4   = $urandom;
        ex_imm_ext     = rand128();
        mem_fwd_result = rand128();
        wb_fwd_result  = rand128();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        mem_clear = 1'b0;
        mem_stall = 1'b0;
        set_op(4'd0, 1'b0, '0, '0);
        tick();
        tick();
        total++;
        if (mem_alu_result !== '0 || mem_instr !== '0 || mem_rd !== '0 || mem_reg_write !== 1'b0 ||
            ex_stall_all !== 1'b0 || mul_state !== 2'd0) begin
            bad++;
            $display("FAIL reset_hold: alu=%h instr=%h rd=%0d stall=%b state=%0d, want all 0",
                     mem_alu_result, mem_instr, mem_rd, ex_stall_all, mul_state);
        end
        reset = 1'b0;
        // load something non-zero, then reset mid-cycle without a clock edge
        set_op(4'd0, 1'b1, rand128(), rand128());
        tick();
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (mem_alu_result !== '0 || mem_instr !== '0 || mem_rd !== '0 || mem_reg_write !== 1'b0 ||
            mem_pc_plus_4 !== '0 || mem_imm_ext !== '0 || mem_write_data !== '0 || ex_stall_all !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: alu=%h instr=%h rd=%0d pc=%h stall=%b, want all 0",
                     mem_alu_result, mem_instr, mem_rd, mem_pc_plus_4, ex_stall_all);
        end
        reset = 1'b0;
    endtask

    task automatic test_add_fwd();
        logic [127:0] a, b;
        a = rand128(); a[31:0] = 32'd5;
        b = rand128(); b[31:0] = 32'd7;
        set_op(4'd0, 1'b0, a, b);
        tick();
        total++;
        if (mem_alu_result !== 128'd12) begin
            bad++;
            $display("FAIL add_rf: got %h want %h", mem_alu_result, 128'd12);
        end
        total++;
        if (mem_rd !== ex_rd || mem_instr !== ex_instr || mem_reg_write !== 1'b1 ||
            mem_result_src !== 2'b01 || mem_write_data !== b || mem_pc_plus_4 !== ex_pc_plus_4) begin
            bad++;
            $display("FAIL add_passthru: rd=%0d/%0d instr=%h/%h wd=%h/%h",
                     mem_rd, ex_rd, mem_instr, ex_instr, mem_write_data, b);
        end
        forward_a      = 2'b10;
        mem_fwd_result = 128'd100;
        tick();
        total++;
        if (mem_alu_result !== 128'd107) begin
            bad++;
            $display("FAIL add_fwd_mem: got %h want %h", mem_alu_result, 128'd107);
        end
    endtask

    task automatic test_vector_ops();
        logic [127:0] exp;
        set_op(4'd1, 1'b1, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd2, 32'd2, 32'd2, 32'd2});
        tick();
        exp = {32'd2, 32'd1, 32'd0, 32'hFFFF_FFFF};
        total++;
        if (mem_alu_result !== exp) begin
            bad++;
            $display("FAIL vec_sub: got %h want %h", mem_alu_result, exp);
        end
        set_op(4'd7, 1'b1, {32'd5, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000}, {32'd5, 32'd2, 32'd0, 32'd1});
        tick();
        exp = {32'd0, 32'd1, 32'd1, 32'd1};
        total++;
        if (mem_alu_result !== exp) begin
            bad++;
            $display("FAIL vec_slt: got %h want %h", mem_alu_result, exp);
        end
    endtask

    task automatic test_random_alu();
        logic [3:0]   op;
        logic [127:0] a, b, exp;
        for (int n = 0; n < 60; n++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'd8) op = 4'd9;
            set_op(op, 1'($urandom), rand128(), rand128());
            forward_a    = 2'($urandom);
            forward_b    = 2'($urandom);
            ex_alu_src   = 1'($urandom);
            ex_mem_write = 1'($urandom);
            ex_mem_read  = 1'($urandom);
            ex_reg_write = 1'($urandom);
            ex_result_src = 2'($urandom);
            a = pick(forward_a, ex_rd1, wb_fwd_result, mem_fwd_result);
            b = pick(forward_b, ex_rd2, wb_fwd_result, mem_fwd_result);
            exp = alu_model(op, ex_vector_op, a, ex_alu_src ? ex_imm_ext : b);
            tick();
            total++;
            if (mem_alu_result !== exp) begin
                bad++;
                $display("FAIL rand_alu op=%0d vec=%b fa=%0d fb=%0d src=%b: got %h want %h",
                         op, ex_vector_op, forward_a, forward_b, ex_alu_src, mem_alu_result, exp);
            end
            total++;
            if (mem_write_data !== b || mem_imm_ext !== ex_imm_ext ||
                {mem_reg_write, mem_mem_write, mem_mem_read, mem_vector_op, mem_result_src} !==
                {ex_reg_write, ex_mem_write, ex_mem_read, ex_vector_op, ex_result_src}) begin
                bad++;
                $display("FAIL rand_ctl: wd=%h want %h ctl=%b%b%b%b%0d", mem_write_data, b,
                         mem_reg_write, mem_mem_write, mem_mem_read, mem_vector_op, mem_result_src);
            end
        end
    endtask

    task automatic test_mul();
        logic [127:0] a, b, exp;
        logic [4:0]   rd;
        int n;
        a = {32'd0, 32'd7, 32'h0000_FFFF, 32'd3};
        b = {32'd9, 32'd6, 32'h0001_0001, 32'd5};
        set_op(4'd8, 1'b1, rand128(), b);
        forward_a      = 2'b10;
        mem_fwd_result = a;
        rd = ex_rd;
        exp = {32'd0, 32'd42, 32'hFFFF_FFFF, 32'd15};
        #1;
        n = 0;
        while (ex_stall_all && n < 20) begin
            n++;
            tick();
            if (n == 1) mem_fwd_result = rand128();
            total++;
            if (mem_reg_write !== 1'b0 || mem_rd !== 5'd0 || mem_instr !== 32'd0) begin
                bad++;
                $display("FAIL mul_bubble cycle %0d: rw=%b rd=%0d instr=%h, want 0",
                         n, mem_reg_write, mem_rd, mem_instr);
            end
        end
        total++;
        if (n != MUL_CYCLES + 1 || mul_state !== 2'd2) begin
            bad++;
            $display("FAIL mul_stall_len: got %0d cycles state=%0d, want %0d cycles state=2",
                     n, mul_state, MUL_CYCLES + 1);
        end
        tick();
        total++;
        if (mem_alu_result !== exp || mem_alu_result !== alu_model(4'd8, 1'b1, a, b)) begin
            bad++;
            $display("FAIL mul_result: got %h want %h", mem_alu_result, exp);
        end
        total++;
        if (mem_rd !== rd || mem_reg_write !== 1'b1 || mul_state !== 2'd0) begin
            bad++;
            $display("FAIL mul_commit: rd=%0d want %0d rw=%b state=%0d", mem_rd, rd, mem_reg_write, mul_state);
        end
        set_op(4'd0, 1'b0, '0, '0);
        tick();
    endtask

    task automatic test_mul_stall();
        logic [127:0] a, b;
        int n;
        a = rand128();
        b = rand128();
        set_op(4'd8, 1'b0, a, b);
        #1;
        n = 0;
        while (ex_stall_all && n < 20) begin
            n++;
            tick();
        end
        mem_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (mul_state !== 2'd2 || ex_stall_all !== 1'b0 || mem_reg_write !== 1'b0 || mem_rd !== 5'd0) begin
                bad++;
                $display("FAIL mul_done_hold %0d: state=%0d stall=%b rw=%b rd=%0d, want 2 0 0 0",
                         k, mul_state, ex_stall_all, mem_reg_write, mem_rd);
            end
        end
        mem_stall = 1'b0;
        tick();
        total++;
        if (mem_alu_result !== alu_model(4'd8, 1'b0, a, b) || mem_rd !== ex_rd || mul_state !== 2'd0) begin
            bad++;
            $display("FAIL mul_after_stall: got %h want %h state=%0d",
                     mem_alu_result, alu_model(4'd8, 1'b0, a, b), mul_state);
        end
        set_op(4'd0, 1'b0, '0, '0);
        tick();
    endtask

    task automatic test_clear();
        logic [127:0] a, b, exp;
        a = rand128();
        b = rand128();
        set_op(4'd4, 1'b1, a, b);
        exp = alu_model(4'd4, 1'b1, a, b);
        tick();
        total++;
        if (mem_alu_result !== exp) begin
            bad++;
            $display("FAIL clear_setup: got %h want %h", mem_alu_result, exp);
        end
        set_op(4'd0, 1'b1, rand128(), rand128());
        mem_stall = 1'b1;
        tick();
        total++;
        if (mem_alu_result !== exp || mem_write_data !== b) begin
            bad++;
            $display("FAIL stall_hold: got %h want %h", mem_alu_result, exp);
        end
        mem_clear = 1'b1;
        tick();
        total++;
        if (mem_alu_result !== '0 || mem_instr !== '0 || mem_rd !== '0 || mem_reg_write !== 1'b0 ||
            mem_vector_op !== 1'b0 || mem_write_data !== '0 || mem_imm_ext !== '0 || mem_pc_plus_4 !== '0) begin
            bad++;
            $display("FAIL clear_over_stall: alu=%h instr=%h rd=%0d, want all 0",
                     mem_alu_result, mem_instr, mem_rd);
        end
        mem_clear = 1'b0;
        mem_stall = 1'b0;
    endtask

    task automatic test_reset_busy();
        set_op(4'd8, 1'b1, rand128(), rand128());
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (ex_stall_all !== 1'b0 || mul_state !== 2'd0 || mem_alu_result !== '0) begin
            bad++;
            $display("FAIL reset_busy: stall=%b state=%0d alu=%h, want 0 0 0",
                     ex_stall_all, mul_state, mem_alu_result);
        end
        set_op(4'd0, 1'b0, 128'd1, 128'd1);
        #1;
        reset = 1'b0;
        tick();
        total++;
        if (mem_alu_result !== 128'd2 || mul_state !== 2'd0) begin
            bad++;
            $display("FAIL after_reset_busy: got %h state=%0d, want 2 state 0", mem_alu_result, mul_state);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] a, b;
        int n;
        for (int m = 0; m < 2; m++) begin
            a = rand128();
            b = rand128();
            set_op(4'd8, 1'b1, a, b);
            #1;
            total++;
            if (ex_stall_all !== 1'b1) begin
                bad++;
                $display("FAIL b2b_start %0d: stall=%b want 1", m, ex_stall_all);
            end
            n = 0;
            while (ex_stall_all && n < 20) begin
                n++;
                tick();
            end
            tick();
            total++;
            if (n != MUL_CYCLES + 1 || mem_alu_result !== alu_model(4'd8, 1'b1, a, b)) begin
                bad++;
                $display("FAIL b2b_result %0d: cycles=%0d got %h want %h",
                         m, n, mem_alu_result, alu_model(4'd8, 1'b1, a, b));
            end
        end
        set_op(4'd0, 1'b0, '0, '0);
        tick();
    endtask

    initial begin
        test_reset();
        tick();
        test_add_fwd();
        test_vector_ops();
        test_random_alu();
        test_mul();
        test_mul_stall();
        test_clear();
        test_reset_busy();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
